// File: rtl/ifelse_branch_decoder_if.sv
// Stream bundle between the if/else generator, the branch decoder and the
// consumer of decoded branch indices.
//   in_valid   : {b,c,d} sample valid this cycle
//   b, c, d    : generator outputs being decoded
//   out_valid  : FIFO head holds a decoded branch
//   out_ready  : consumer accepts the head this cycle
//   out_branch : decoded branch index at the FIFO head
// The slave modport is the decoder's view; master is the surrounding logic.
interface ifelse_branch_decoder_if;
  logic       in_valid;
  logic       b;
  logic       c;
  logic [1:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_branch;

  modport slave (
    input  in_valid, b, c, d, out_ready,
    output out_valid, out_branch
  );

  modport master (
    output in_valid, b, c, d, out_ready,
    input  out_valid, out_branch
  );
endinterface

// File: rtl/ifelse_branch_decoder.sv
// Recovers the branch index from samples of the if/else generator outputs,
// queues decoded indices in a small FIFO drained over a valid/ready stream,
// and keeps saturating per-branch hit counters plus an illegal-pattern count.
//   clock       : system clock, all state on the rising edge
//   reset       : synchronous, active-high
//   bus         : sample input and decoded-branch output stream (slave side)
//   cnt0..cnt3  : per-branch hit counts (saturating)
//   illegal_cnt : count of undecodable samples (saturating)
//   overflow    : sticky, a legal sample was dropped on a full FIFO
module ifelse_branch_decoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  ifelse_branch_decoder_if.slave bus,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1,
  output logic [CNT_W-1:0]     cnt2,
  output logic [CNT_W-1:0]     cnt3,
  output logic [CNT_W-1:0]     illegal_cnt,
  output logic                 overflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullOcc = (PtrW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [1:0]      mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   occ_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] illegal_q;
  logic            overflow_q;

  logic       legal;
  logic [1:0] branch;
  logic       full, pop, push, drop;

  // Combinational decode of {b, c, d[1:0]}.
  always_comb begin
    legal  = 1'b1;
    branch = 2'd0;
    case ({bus.b, bus.c, bus.d})
      4'b1000: branch = 2'd0;
      4'b0100: branch = 2'd1;
      4'b1001: branch = 2'd2;
      4'b0011: branch = 2'd3;
      default: legal  = 1'b0;
    endcase
  end

  always_comb begin
    full = (occ_q == FullOcc);
    pop  = bus.out_valid && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push = bus.in_valid && legal && (!full || pop);
    drop = bus.in_valid && legal && full && !pop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
      illegal_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        if (legal) begin
          if (cnt_q[branch] != CntMax) cnt_q[branch] <= cnt_q[branch] + 1'b1;
        end else if (illegal_q != CntMax) begin
          illegal_q <= illegal_q + 1'b1;
        end
      end
      if (push) begin
        mem_q[wr_ptr_q] <= branch;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.out_valid  = (occ_q != '0);
  assign bus.out_branch = mem_q[rd_ptr_q];
  assign cnt0           = cnt_q[0];
  assign cnt1           = cnt_q[1];
  assign cnt2           = cnt_q[2];
  assign cnt3           = cnt_q[3];
  assign illegal_cnt    = illegal_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_ifelse_branch_decoder.sv
module tb_ifelse_branch_decoder;
  logic       clock;
  logic       reset;
  logic [7:0] cnt0, cnt1, cnt2, cnt3, illegal_cnt;
  logic       overflow;
  int         total;
  int         bad;

  ifelse_branch_decoder_if bus ();

  ifelse_branch_decoder #(.DEPTH(4), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .cnt0        (cnt0),
    .cnt1        (cnt1),
    .cnt2        (cnt2),
    .cnt3        (cnt3),
    .illegal_cnt (illegal_cnt),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle; inputs change only here.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.b = 1'b0;
    bus.c = 1'b0;
    bus.d = 2'b00;
  endtask

  // Encoded generator outputs for each branch index.
  task automatic set_branch(input int br);
    bus.in_valid = 1'b1;
    case (br)
      0: begin bus.b = 1'b1; bus.c = 1'b0; bus.d = 2'b00; end
      1: begin bus.b = 1'b0; bus.c = 1'b1; bus.d = 2'b00; end
      2: begin bus.b = 1'b1; bus.c = 1'b0; bus.d = 2'b01; end
      default: begin bus.b = 1'b0; bus.c = 1'b0; bus.d = 2'b11; end
    endcase
  endtask

  task automatic do_reset();
    idle();
    bus.out_ready = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_branch !== 2'd0) begin bad++; $display("FAIL reset_branch got=%0d exp=0", bus.out_branch); end
    total++; if ({cnt0, cnt1, cnt2, cnt3, illegal_cnt} !== 40'd0) begin bad++;
      $display("FAIL reset_counters got=%0d/%0d/%0d/%0d/%0d exp=0", cnt0, cnt1, cnt2, cnt3, illegal_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_legal();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_branch(i);
      cyc();
      total++; if (bus.out_valid !== 1'b1 || bus.out_branch !== 2'(i)) begin bad++;
        $display("FAIL legal_head%0d got=%b/%0d exp=1/%0d", i, bus.out_valid, bus.out_branch, i); end
    end
    idle();
    cyc();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL legal_drain got=%b exp=0", bus.out_valid); end
    total++; if (cnt0 !== 8'd1 || cnt1 !== 8'd1 || cnt2 !== 8'd1 || cnt3 !== 8'd1) begin bad++;
      $display("FAIL legal_cnts got=%0d/%0d/%0d/%0d exp=1/1/1/1", cnt0, cnt1, cnt2, cnt3); end
    total++; if (illegal_cnt !== 8'd0) begin bad++; $display("FAIL legal_illegal got=%0d exp=0", illegal_cnt); end
  endtask

  task automatic test_illegal();
    logic [3:0] pats [3];
    pats[0] = 4'b1100;
    pats[1] = 4'b0000;
    pats[2] = 4'b1010;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      {bus.b, bus.c, bus.d} = pats[i];
      cyc();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL illegal_valid%0d got=%b exp=0", i, bus.out_valid); end
    end
    idle();
    cyc();
    total++; if (illegal_cnt !== 8'd3) begin bad++; $display("FAIL illegal_cnt got=%0d exp=3", illegal_cnt); end
    total++; if ({cnt0, cnt1, cnt2, cnt3} !== 32'd0) begin bad++;
      $display("FAIL illegal_cnts got=%0d/%0d/%0d/%0d exp=0", cnt0, cnt1, cnt2, cnt3); end
  endtask

  task automatic test_overflow();
    int pops;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_branch(1);
      cyc();
    end
    idle();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if (cnt1 !== 8'd5) begin bad++; $display("FAIL ovf_cnt1 got=%0d exp=5", cnt1); end
    bus.out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) begin
        pops++;
        total++; if (bus.out_branch !== 2'd1) begin bad++; $display("FAIL ovf_branch got=%0d exp=1", bus.out_branch); end
      end
      cyc();
    end
    total++; if (pops !== 4) begin bad++; $display("FAIL ovf_pops got=%0d exp=4", pops); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", bus.out_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [1:0] exp [4];
    int n;
    exp[0] = 2'd1; exp[1] = 2'd2; exp[2] = 2'd3; exp[3] = 2'd3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_branch(i);
      cyc();
    end
    // Full with branch 0 at head: pop it and push branch 3 together.
    bus.out_ready = 1'b1;
    set_branch(3);
    cyc();
    bus.out_ready = 1'b0;
    idle();
    cyc();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
    bus.out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) begin
        if (n < 4) begin
          total++; if (bus.out_branch !== exp[n]) begin bad++;
            $display("FAIL fpp_entry%0d got=%0d exp=%0d", n, bus.out_branch, exp[n]); end
        end
        n++;
      end
      cyc();
    end
    total++; if (n !== 4) begin bad++; $display("FAIL fpp_occupancy got=%0d exp=4", n); end
  endtask

  task automatic test_head_stable();
    do_reset();
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    bus.out_ready = 1'b0;
    set_branch(2);
    cyc();
    set_branch(3);
    cyc();
    idle();
    cyc();
    total++; if (bus.out_valid !== 1'b1 || bus.out_branch !== 2'd2) begin bad++;
      $display("FAIL hold_head got=%b/%0d exp=1/2", bus.out_valid, bus.out_branch); end
    bus.out_ready = 1'b1;
    cyc();
    total++; if (bus.out_branch !== 2'd3) begin bad++; $display("FAIL hold_next got=%0d exp=3", bus.out_branch); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_branch(0);
      cyc();
      if (i == 254) begin
        total++; if (cnt0 !== 8'd255) begin bad++; $display("FAIL sat_reach got=%0d exp=255", cnt0); end
      end
    end
    idle();
    cyc();
    total++; if (cnt0 !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", cnt0); end
    total++; if ({cnt1, cnt2, cnt3, illegal_cnt} !== 32'd0) begin bad++;
      $display("FAIL sat_others got=%0d/%0d/%0d/%0d exp=0", cnt1, cnt2, cnt3, illegal_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sat_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_branch(2);
      cyc();
    end
    set_branch(0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    idle();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", bus.out_valid); end
    total++; if ({cnt0, cnt1, cnt2, cnt3, illegal_cnt} !== 40'd0) begin bad++;
      $display("FAIL mid_counters got=%0d/%0d/%0d/%0d/%0d exp=0", cnt0, cnt1, cnt2, cnt3, illegal_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
    cyc();
    total++; if (cnt0 !== 8'd0 || bus.out_valid !== 1'b0) begin bad++;
      $display("FAIL mid_after got=%0d/%b exp=0/0", cnt0, bus.out_valid); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.out_ready = 1'b0;
    idle();
    test_reset();
    test_legal();
    test_illegal();
    test_overflow();
    test_full_push_pop();
    test_head_stable();
    test_saturation();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
